// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write-through forwarding and a
// pending-bit scoreboard that raises one decode stall for RAW, WAW and sync-drain hazards.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 5,
  parameter int RPORTS = 2,
  parameter int WPORTS = 2
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     is_stalling,
  input  logic [RPORTS*ID_W-1:0]   rd_id,
  input  logic [RPORTS-1:0]        rd_en,
  output logic [RPORTS*DATA_W-1:0] rd_data,
  input  logic [WPORTS-1:0]        wr_en,
  input  logic [WPORTS*ID_W-1:0]   wr_id,
  input  logic [WPORTS*DATA_W-1:0] wr_data,
  input  logic [WPORTS-1:0]        wr_clr,
  input  logic                     iss_valid,
  input  logic [ID_W-1:0]          iss_dst,
  input  logic                     iss_long,
  input  logic                     sync_req,
  output logic                     stall,
  output logic                     any_pending,
  output logic [ID_W:0]            pend_cnt
);
  localparam int NREGS = 2 ** ID_W;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d, clr_now, eff_pend;
  logic              raw, waw, drain;
  always_comb begin
    clr_now = '0;
    for (int j = 0; j < WPORTS; j++)
      if (wr_en[j] && wr_clr[j]) clr_now[wr_id[j*ID_W +: ID_W]] = 1'b1;
    clr_now[0] = 1'b0;
  end
  // Completing writes hide their pending bit so the consumer proceeds on forwarded data.
  assign eff_pend = pend_q & ~clr_now;
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < RPORTS; k++)
      if (rd_en[k] && eff_pend[rd_id[k*ID_W +: ID_W]]) raw = 1'b1;
  end
  assign waw   = (iss_dst != '0) && eff_pend[iss_dst];
  assign drain = sync_req && (|eff_pend);
  assign stall = iss_valid && (raw || waw || drain);
  always_comb begin
    pend_d = eff_pend;
    if (iss_valid && !stall && iss_long && iss_dst != '0) pend_d[iss_dst] = 1'b1;
  end
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RPORTS; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[rd_id[k*ID_W +: ID_W]];
      for (int j = 0; j < WPORTS; j++)
        if (wr_en[j] && wr_id[j*ID_W +: ID_W] == rd_id[k*ID_W +: ID_W] && rd_id[k*ID_W +: ID_W] != '0)
          rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
    end
  end
  always_comb begin
    pend_cnt = '0;
    for (int r = 0; r < NREGS; r++) pend_cnt = pend_cnt + (ID_W+1)'(pend_q[r]);
  end
  assign any_pending = |pend_q;
  // Register 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (!is_stalling) begin
      pend_q <= pend_d;
      for (int j = 0; j < WPORTS; j++)
        if (wr_en[j] && wr_id[j*ID_W +: ID_W] != '0) regs_q[wr_id[j*ID_W +: ID_W]] <= wr_data[j*DATA_W +: DATA_W];
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus randomized run against a reference model.
module tb_regfile_scoreboard;
  localparam int DW = 32, IW = 5, RP = 2, WP = 2;
  logic sys_clk = 1'b0;
  logic rst_n, is_stalling, iss_valid, iss_long, sync_req, stall, any_pending;
  logic [RP*IW-1:0] rd_id;
  logic [RP-1:0]    rd_en;
  logic [RP*DW-1:0] rd_data;
  logic [WP-1:0]    wr_en, wr_clr;
  logic [WP*IW-1:0] wr_id;
  logic [WP*DW-1:0] wr_data;
  logic [IW-1:0]    iss_dst;
  logic [IW:0]      pend_cnt;
  always #5 sys_clk = ~sys_clk;
  regfile_scoreboard #(.DATA_W(DW), .ID_W(IW), .RPORTS(RP), .WPORTS(WP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .is_stalling(is_stalling), .rd_id(rd_id), .rd_en(rd_en),
    .rd_data(rd_data), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_long(iss_long), .sync_req(sync_req),
    .stall(stall), .any_pending(any_pending), .pend_cnt(pend_cnt)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] rst, hold, rid0, rid1, ren, wen, wid0, wd0, wid1, wd1, wclr, iv, idst, il, sync,
                 e_rd0, e_rd1, e_stall, e_cnt;
  } vec_t;
  vec_t tbl[31];
  task automatic apply(vec_t v);
    rst_n = !v.rst[0];
    is_stalling = v.hold[0];
    rd_id = {v.rid1[IW-1:0], v.rid0[IW-1:0]};
    rd_en = v.ren[1:0];
    wr_en = v.wen[1:0];
    wr_id = {v.wid1[IW-1:0], v.wid0[IW-1:0]};
    wr_data = {v.wd1, v.wd0};
    wr_clr = v.wclr[1:0];
    iss_valid = v.iv[0];
    iss_dst = v.idst[IW-1:0];
    iss_long = v.il[0];
    sync_req = v.sync[0];
  endtask
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  bit          clr [32];
  logic [4:0]  rid [2], wid [2];
  logic [31:0] wd [2], e_rd;
  logic [1:0]  ren, wen, wcl;
  bit          hold, rst, iv, il, sy, e_stall;
  logic [4:0]  dst;
  int          cnt;
  initial begin
    tbl = '{
      //  rst hold rid0 rid1 ren wen wid0 wd0 wid1 wd1 wclr iv idst il sync | rd0 rd1 stall cnt
      '{1,0,5,5,3,1,5,'hAAAA,0,0,0,1,6,1,0, 0,0,0,0},
      '{0,0,0,5,3,0,0,0,0,0,0,0,0,0,0, 0,0,0,0},
      '{0,0,5,5,3,1,5,'hDEADBEEF,0,0,0,0,0,0,0, 'hDEADBEEF,'hDEADBEEF,0,0},
      '{0,0,5,0,3,0,0,0,0,0,0,0,0,0,0, 'hDEADBEEF,0,0,0},
      '{0,0,7,7,3,3,7,'h11,7,'h22,0,0,0,0,0, 'h22,'h22,0,0},
      '{0,0,7,0,3,1,0,'h55,0,0,0,0,0,0,0, 'h22,0,0,0},
      '{0,0,0,7,3,0,0,0,0,0,0,0,0,0,0, 0,'h22,0,0},
      '{0,0,0,0,0,0,0,0,0,0,0,1,8,1,0, 0,0,0,0},
      '{0,0,8,0,1,0,0,0,0,0,0,1,10,0,0, 0,0,1,1},
      '{0,0,8,0,1,0,0,0,0,0,0,1,10,0,0, 0,0,1,1},
      '{0,0,8,0,1,0,0,0,0,0,0,1,10,0,0, 0,0,1,1},
      '{0,0,8,0,1,2,0,0,8,'h1234,2,1,10,0,0, 'h1234,0,0,1},
      '{0,0,8,0,1,0,0,0,0,0,0,1,9,1,0, 'h1234,0,0,0},
      '{0,0,0,0,0,0,0,0,0,0,0,1,9,0,0, 0,0,1,1},
      '{0,0,9,0,0,1,9,'h99,0,0,1,1,9,1,0, 'h99,0,0,1},
      '{0,0,9,0,1,0,0,0,0,0,0,1,11,0,0, 'h99,0,1,1},
      '{0,0,9,0,1,2,0,0,9,'h9A,2,0,0,0,0, 'h9A,0,0,1},
      '{0,0,0,0,0,0,0,0,0,0,0,1,3,1,0, 0,0,0,0},
      '{0,0,0,0,0,0,0,0,0,0,0,1,4,1,0, 0,0,0,1},
      '{0,0,0,0,0,0,0,0,0,0,0,1,0,0,1, 0,0,1,2},
      '{0,0,3,0,0,1,3,'h33,0,0,1,1,0,0,1, 'h33,0,1,2},
      '{0,1,4,0,0,1,4,'h44,0,0,1,1,0,0,1, 'h44,0,0,1},
      '{0,0,4,0,0,0,0,0,0,0,0,1,0,0,1, 0,0,1,1},
      '{0,0,4,0,0,2,0,0,4,'h45,2,1,0,0,1, 'h45,0,0,1},
      '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,0, 0,0,0,0},
      '{0,0,0,0,0,0,0,0,0,0,0,1,2,1,0, 0,0,0,1},
      '{0,0,0,0,0,0,0,0,0,0,0,1,3,1,0, 0,0,0,2},
      '{0,0,0,0,0,0,0,0,0,0,0,1,4,1,0, 0,0,0,3},
      '{0,0,1,0,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,4},
      '{1,0,1,2,3,0,0,0,0,0,0,0,0,0,0, 0,0,0,0},
      '{0,0,1,5,3,0,0,0,0,0,0,1,3,0,0, 0,0,0,0}
    };
    apply(tbl[0]);
    @(posedge sys_clk); #1;
    for (int i = 0; i < 31; i++) begin
      apply(tbl[i]);
      #4;
      if (!tbl[i].rst[0]) begin
        chk($sformatf("row%0d rd0", i), rd_data[31:0], tbl[i].e_rd0);
        chk($sformatf("row%0d rd1", i), rd_data[63:32], tbl[i].e_rd1);
        chk($sformatf("row%0d stall", i), {31'b0, stall}, tbl[i].e_stall);
        chk($sformatf("row%0d pend_cnt", i), {26'b0, pend_cnt}, tbl[i].e_cnt);
        chk($sformatf("row%0d any_pending", i), {31'b0, any_pending}, {31'b0, tbl[i].e_cnt != 0});
      end
      @(posedge sys_clk); #1;
    end
    apply(tbl[29]);
    @(posedge sys_clk); #1;
    for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_pend[r] = 0; end
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(63) == 0);
      hold = ($urandom_range(7) == 0);
      for (int k = 0; k < 2; k++) begin
        rid[k] = 5'($urandom_range(7));
        wid[k] = 5'($urandom_range(7));
        wd[k] = $urandom;
      end
      ren = 2'($urandom_range(3));
      wen = 2'($urandom_range(3));
      wcl = 2'($urandom_range(3));
      iv = 1'($urandom_range(1));
      il = 1'($urandom_range(1));
      sy = ($urandom_range(7) == 0);
      dst = 5'($urandom_range(7));
      rst_n = !rst; is_stalling = hold; rd_id = {rid[1], rid[0]}; rd_en = ren;
      wr_en = wen; wr_id = {wid[1], wid[0]}; wr_data = {wd[1], wd[0]}; wr_clr = wcl;
      iss_valid = iv; iss_dst = dst; iss_long = il; sync_req = sy;
      for (int r = 0; r < 32; r++) clr[r] = 0;
      for (int j = 0; j < 2; j++) if (wen[j] && wcl[j] && wid[j] != 0) clr[wid[j]] = 1;
      cnt = 0;
      e_stall = 0;
      for (int r = 0; r < 32; r++) begin
        cnt += int'(m_pend[r]);
        if (sy && m_pend[r] && !clr[r]) e_stall = 1;
      end
      if (dst != 0 && m_pend[dst] && !clr[dst]) e_stall = 1;
      for (int k = 0; k < 2; k++) if (ren[k] && m_pend[rid[k]] && !clr[rid[k]]) e_stall = 1;
      e_stall = e_stall && iv;
      #4;
      for (int k = 0; k < 2; k++) begin
        e_rd = m_reg[rid[k]];
        for (int j = 0; j < 2; j++) if (wen[j] && wid[j] == rid[k] && rid[k] != 0) e_rd = wd[j];
        chk($sformatf("rnd%0d rd%0d", c, k), rd_data[k*32 +: 32], e_rd);
      end
      chk($sformatf("rnd%0d stall", c), {31'b0, stall}, {31'b0, e_stall});
      chk($sformatf("rnd%0d pend_cnt", c), {26'b0, pend_cnt}, 32'(cnt));
      chk($sformatf("rnd%0d any_pending", c), {31'b0, any_pending}, {31'b0, cnt != 0});
      if (rst) begin
        for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_pend[r] = 0; end
      end else if (!hold) begin
        for (int j = 0; j < 2; j++) if (wen[j] && wid[j] != 0) m_reg[wid[j]] = wd[j];
        for (int r = 0; r < 32; r++) if (clr[r]) m_pend[r] = 0;
        if (iv && !e_stall && il && dst != 0) m_pend[dst] = 1;
      end
      @(posedge sys_clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the ID-stage register file and load-use bubble logic.
- N read ports, M write-back ports, write-through forwarding.
- Per-register pending scoreboard for long-latency producers (loads, mul/div).
- Produces a single decode stall covering RAW, WAW and sync-drain hazards; sits in ID, fed by all WB sources.

Parameters:
DATA_W, 32, register data width
ID_W, 5, register index width; NREGS = 2**ID_W, register 0 hardwired zero
RPORTS, 2, number of combinational read ports
WPORTS, 2, number of write-back ports; higher index wins on same-register conflict

Ports:
sys_clk  in  1  clock
rst_n  in  1  synchronous active-low reset
is_stalling  in  1  pipeline hold; suppresses register writes and scoreboard set/clear
rd_id  in  RPORTS*ID_W  read indices, port k at [k*ID_W +: ID_W]
rd_en  in  RPORTS  read port k is a real source operand (hazard check enable)
rd_data  out  RPORTS*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
wr_en  in  WPORTS  write strobe per port
wr_id  in  WPORTS*ID_W  write indices
wr_data  in  WPORTS*DATA_W  write data
wr_clr  in  WPORTS  this write completes a long-latency op; clears pending
iss_valid  in  1  decoding instruction issues this cycle if not stalled
iss_dst  in  ID_W  destination of decoding instruction
iss_long  in  1  destination is produced by a long-latency unit
sync_req  in  1  decoding instruction is a sync; must drain scoreboard
stall  out  1  hold IF/ID, inject bubble into ID/EX
any_pending  out  1  OR of all pending bits
pend_cnt  out  ID_W+1  number of pending registers

Behaviour:
- Reset (rst_n low at posedge sys_clk): all registers 0, all pending bits 0; writes and issues in that cycle ignored. Asserting reset mid-operation drops all pending state. A late wr_clr arriving after reset is harmless: it writes data and clears an already-clear bit.
- Outputs after reset: any_pending=0, pend_cnt=0. rd_data and stall are combinational.
- Register 0:
  - Reads always 0.
  - Never written and never pending.
  - Issue or clear targeting 0 is ignored.
- Write: at posedge, when !is_stalling and wr_en[j], register[wr_id[j]] <= wr_data[j]. If several ports hit the same index, the highest j wins.
- Read forwarding, combinational:
  - rd_data[k] = wr_data of the highest j with wr_en[j] && wr_id[j]==rd_id[k] && rd_id[k]!=0; otherwise the stored value.
  - Forwarding is independent of is_stalling.
- Clearing set this cycle: clr_now[r] = OR over j of (wr_en[j] && wr_clr[j] && wr_id[j]==r).
- Effective pending: eff_pend[r] = pend[r] && !clr_now[r], so completing writes bypass the scoreboard.
- Stall, combinational: stall = iss_valid && (raw || waw || drain).
  - raw = any k with rd_en[k] && eff_pend[rd_id[k]].
  - waw = iss_dst!=0 && eff_pend[iss_dst].
  - drain = sync_req && any eff_pend.
- Scoreboard update at posedge, only when !is_stalling:
  - Clear: pend[r] <= 0 for every r with clr_now[r].
  - Set: if iss_valid && !stall && iss_long && iss_dst!=0, pend[iss_dst] <= 1. Set has priority over clear on the same index in the same cycle.
- is_stalling high: register file and pend hold. Producers must re-present writes; the WB stage guarantees this.
- pend_cnt and any_pending are combinational from the registered pend; they do not include the same-cycle clear.
- Latency: a long op issued at cycle t makes pend visible at t+1. A dependent instruction stalls until the cycle its wr_clr write appears and proceeds in that same cycle using the forwarded data.
- A write with wr_clr=0 to a pending register (should not occur) updates data only; pend stays set.

Test Plan:
- Reset, then read all ports at r0 and r5 -> rd_data=0, stall=0, pend_cnt=0. Write r5=0xDEADBEEF via port 0 -> same-cycle read of r5 returns 0xDEADBEEF; next cycle stored value returned.
- Port 0 and port 1 both write r7 (0x11, 0x22) -> forwarded and stored value 0x22; write to r0 -> r0 stays 0.
- Long issue to r8 (iss_long=1) -> pend_cnt=1. Next cycle read r8 with rd_en=1 -> stall=1 for 3 cycles. Port 1 wr_clr to r8 with 0x1234 -> stall=0 in that cycle, rd_data=0x1234, pend_cnt=0 next cycle.
- WAW: r9 pending, issue r9 -> stall=1. Same cycle as r9 clear, issue long r9 -> stall=0 and r9 remains pending (set wins).
- Sync: r3 and r4 pending, sync_req=1 -> stall until both cleared. is_stalling=1 during a wr_clr -> pend unchanged, register unchanged.
- Reset asserted with 4 pending registers -> next cycle pend_cnt=0, any_pending=0, no stall on reads of those registers.
